// File: rtl/shake_padder_if.sv
// Stream bundle between the message source and the SHAKE padder, plus the padded-block
// output toward the absorb stage. The master side feeds messages; the slave side is the padder.
interface shake_padder_if #(
  parameter int unsigned W = 64
);
  localparam int unsigned BytesW = $clog2(W / 8) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              in_last;
  logic [BytesW-1:0] in_bytes;

  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_block_last;
  logic              out_msg_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_data, out_block_last, out_msg_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_data, out_block_last, out_msg_last
  );
endinterface

// File: rtl/shake_padder.sv
// SHAKE pad10*1 front end: passes message words through and appends domain/pad words so the
// output is a whole number of rate blocks. SHAKE_PADDER_BYTE_MASK_EN zeroes unused final bytes.
module shake_padder #(
  parameter int unsigned W          = 64,
  parameter int unsigned RATE_WORDS = 17,
  parameter logic [7:0]  DOMAIN     = 8'h1F
) (
  input logic            clk,
  input logic            rst_n,
  shake_padder_if.slave  bus
);
  localparam int unsigned Nb     = W / 8;
  localparam int unsigned BytesW = $clog2(Nb) + 1;
  localparam int unsigned IdxW   = $clog2(RATE_WORDS);
  localparam logic [IdxW-1:0]   IdxEnd    = IdxW'(RATE_WORDS - 1);
  localparam logic [BytesW-1:0] BytesFull = BytesW'(Nb);

  typedef enum logic [1:0] {StMsg, StPadFirst, StZeroFill} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              run_q;

  logic              at_end;
  logic              short_last;
  logic              fire;
  logic [BytesW-1:0] bytes_eff;
  logic [W-1:0]      final_word;

  logic              in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_block_last;
  logic              out_msg_last;

  assign at_end     = (idx_q == IdxEnd);
  assign bytes_eff  = (bus.in_bytes > BytesFull) ? BytesFull : bus.in_bytes;
  assign short_last = bus.in_last && (bytes_eff != BytesFull);
  assign fire       = out_valid && bus.out_ready;

  // Final short word: domain byte ORed in at the first unused byte position.
  always_comb begin
    final_word = bus.in_data;
    for (int unsigned i = 0; i < Nb; i++) begin
`ifdef SHAKE_PADDER_BYTE_MASK_EN
      if (BytesW'(i) >= bytes_eff) final_word[8*i +: 8] = 8'h00;
`endif
      if (BytesW'(i) == bytes_eff) final_word[8*i +: 8] = final_word[8*i +: 8] | DOMAIN;
    end
  end

  // run_q keeps all outputs quiet until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StMsg;
      idx_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (fire) begin
      idx_d = at_end ? '0 : idx_q + 1'b1;
      unique case (state_q)
        StMsg: begin
          if (bus.in_last) begin
            if (!short_last)  state_d = StPadFirst;
            else if (!at_end) state_d = StZeroFill;
          end
        end
        StPadFirst: state_d = at_end ? StMsg : StZeroFill;
        StZeroFill: if (at_end) state_d = StMsg;
        default:    state_d = StMsg;
      endcase
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_block_last = 1'b0;
    out_msg_last   = 1'b0;
    if (run_q) begin
      out_block_last = at_end;
      unique case (state_q)
        StMsg: begin
          in_ready  = bus.out_ready;
          out_valid = bus.in_valid;
          out_data  = bus.in_data;
          if (short_last) begin
            out_data = final_word;
            if (at_end) begin
              out_data[W-1 -: 8] = out_data[W-1 -: 8] | 8'h80;
              out_msg_last       = 1'b1;
            end
          end
        end
        StPadFirst: begin
          out_valid     = 1'b1;
          out_data[7:0] = DOMAIN;
          if (at_end) begin
            out_data[W-1 -: 8] = out_data[W-1 -: 8] | 8'h80;
            out_msg_last       = 1'b1;
          end
        end
        StZeroFill: begin
          out_valid = 1'b1;
          if (at_end) begin
            out_data[W-1 -: 8] = 8'h80;
            out_msg_last       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = out_data;
  assign bus.out_block_last = out_block_last;
  assign bus.out_msg_last   = out_msg_last;
endmodule

// File: tb/tb_shake_padder.sv
// Bench for shake_padder: byte-level pad10*1 model feeding a scoreboard, checked on every
// output handshake, plus literal expectations on logged output words.
module tb_shake_padder;
  localparam int unsigned W    = 64;
  localparam int unsigned RATE = 17;
  localparam int unsigned NB   = W / 8;
  localparam logic [7:0]  DOM  = 8'h1F;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [W-1:0] data;
    logic         blk;
    logic         last;
    logic         rdy;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;
  int           out_count = 0;
  logic [W-1:0] log_data[1024];
  logic [1:0]   log_flags[1024];
  bit           bp_en = 1'b0;

  shake_padder_if #(.W(W)) bus ();

  shake_padder #(.W(W), .RATE_WORDS(RATE), .DOMAIN(DOM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Whole padded message as bytes: msg || DOMAIN || 0* with 0x80 ORed into the last byte.
  task automatic push_msg(input bq_t msg, input logic [W-1:0] junk);
    int n, blk, total, n_in, base;
    logic [7:0] pad[];
    exp_t e;
    n     = msg.size();
    blk   = RATE * NB;
    total = blk * ((n + blk) / blk);
    n_in  = (n == 0) ? 1 : (n + NB - 1) / NB;
    pad   = new[total];
    foreach (pad[i]) pad[i] = (i < n) ? msg[i] : 8'h00;
`ifndef SHAKE_PADDER_BYTE_MASK_EN
    base = (n_in - 1) * NB;
    for (int b = 0; b < NB; b++) pad[base + b] = pad[base + b] | junk[8*b +: 8];
`else
    base = 0;
    if (junk != 0 && base != 0) pad[0] = pad[0];
`endif
    pad[n]         = pad[n] | DOM;
    pad[total - 1] = pad[total - 1] | 8'h80;
    for (int w = 0; w < total / NB; w++) begin
      e.data = '0;
      for (int b = 0; b < NB; b++) e.data[8*b +: 8] = pad[w*NB + b];
      e.blk  = (w % RATE) == RATE - 1;
      e.last = (w == total / NB - 1);
      e.rdy  = (w < n_in);
      sb.push_back(e);
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l, input int nb);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = 4'(nb);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("input accept timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic send_msg(input bq_t msg, input logic [W-1:0] junk, input int bytes_ovr);
    int n, n_in, nb;
    logic [W-1:0] d;
    push_msg(msg, junk);
    n    = msg.size();
    n_in = (n == 0) ? 1 : (n + NB - 1) / NB;
    for (int w = 0; w < n_in; w++) begin
      d = '0;
      for (int b = 0; b < NB; b++) if (w*NB + b < n) d[8*b +: 8] = msg[w*NB + b];
      nb = NB;
      if (w == n_in - 1) begin
        d  = d | junk;
        nb = (bytes_ovr >= 0) ? bytes_ovr : n - w*NB;
      end
      send_word(d, w == n_in - 1, nb);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  // Compare process: every output handshake is checked against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_count = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected output word", 64'd1, 64'd0);
      end else begin
        cur = sb.pop_front();
        check("out_data", bus.out_data, cur.data);
        check("flags {in_ready,block_last,msg_last}",
              64'({bus.in_ready, bus.out_block_last, bus.out_msg_last}),
              64'({cur.rdy, cur.blk, cur.last}));
      end
      log_data[out_count % 1024]  = bus.out_data;
      log_flags[out_count % 1024] = {bus.out_block_last, bus.out_msg_last};
      out_count++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t m, m2;
    int base;
    logic [W-1:0] held;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h1234;
    bus.in_last   = 1'b1;
    bus.in_bytes  = 4'd2;
    bus.out_ready = 1'b1;
    #12;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset out_block_last", 64'(bus.out_block_last), 64'd0);
    check("reset out_msg_last", 64'(bus.out_msg_last), 64'd0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle out_valid", 64'(bus.out_valid), 64'd0);
    check("idle in_ready", 64'(bus.in_ready), 64'd1);

    // Empty message.
    m.delete();
    base = out_count;
    send_msg(m, '0, -1);
    drain();
    check("empty count", 64'(out_count - base), 64'd17);
    check("empty word0", log_data[base], 64'h1F);
    check("empty word16", log_data[base + 16], 64'h8000_0000_0000_0000);
    check("empty word16 flags", 64'(log_flags[base + 16]), 64'd3);

    // "abc".
    m = {8'h61, 8'h62, 8'h63};
    base = out_count;
    send_msg(m, '0, -1);
    drain();
    check("abc word0", log_data[base], 64'h1F63_6261);
    check("abc word16", log_data[base + 16], 64'h8000_0000_0000_0000);

    // 136 then 135 bytes back-to-back under random backpressure.
    m.delete();
    for (int i = 0; i < 136; i++) m.push_back(8'(i * 7 + 3));
    m2.delete();
    for (int i = 0; i < 128; i++) m2.push_back(8'(i * 7 + 3));
    for (int i = 0; i < 7; i++) m2.push_back(8'hAA);
    base  = out_count;
    bp_en = 1'b1;
    send_msg(m, '0, -1);
    send_msg(m2, '0, -1);
    drain();
    bp_en         = 1'b0;
    bus.out_ready = 1'b1;
    check("136+135 count", 64'(out_count - base), 64'd51);
    check("136 word16 flags", 64'(log_flags[base + 16]), 64'd2);
    check("136 word17", log_data[base + 17], 64'h1F);
    check("136 word33", log_data[base + 33], 64'h8000_0000_0000_0000);
    check("135 word16", log_data[base + 50], 64'h9FAA_AAAA_AAAA_AAAA);
    check("135 word16 flags", 64'(log_flags[base + 50]), 64'd3);

    // Nonzero upstream bytes above in_bytes.
    m = {8'h31, 8'h32};
    base = out_count;
    send_msg(m, 64'hFFFF_FFFF_FFFF_0000, -1);
    drain();
`ifdef SHAKE_PADDER_BYTE_MASK_EN
    check("junk word0 masked", log_data[base], 64'h1F_3231);
`else
    check("junk word0 unmasked", log_data[base], 64'hFFFF_FFFF_FFFF_3231);
`endif

    // in_bytes above W/8 behaves as a full final word.
    m.delete();
    for (int i = 1; i <= 8; i++) m.push_back(8'(i));
    base = out_count;
    send_msg(m, '0, 15);
    drain();
    check("ovr word0", log_data[base], 64'h0807_0605_0403_0201);
    check("ovr word1", log_data[base + 1], 64'h1F);

    // Stall in zero fill at idx 5, then reset at idx 9.
    m.delete();
    push_msg(m, '0);
    send_word('0, 1'b1, 0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    base = out_count - 1;
    for (int t = 0; t < 100; t++) begin
      if (out_count - base == 5) break;
      @(posedge clk);
      #1;
    end
    check("stall reached idx5", 64'(out_count - base), 64'd5);
    bus.out_ready = 1'b0;
    @(negedge clk);
    held = bus.out_data;
    check("stall out_valid", 64'(bus.out_valid), 64'd1);
    check("stall in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("stall data stable", bus.out_data, held);
    check("stall data zero", bus.out_data, 64'd0);
    check("stall no handshake", 64'(out_count - base), 64'd5);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (out_count - base == 9) break;
      @(posedge clk);
      #1;
    end
    check("reached idx9", 64'(out_count - base), 64'd9);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    check("mid reset in_ready", 64'(bus.in_ready), 64'd0);
    check("mid reset flags", 64'({bus.out_block_last, bus.out_msg_last}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset out_valid", 64'(bus.out_valid), 64'd0);
    check("post reset count", 64'(out_count), 64'd0);

    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, '0, -1);
    drain();
    check("post reset word0", log_data[0], 64'h1F63_6261);
    check("post reset word15 flags", 64'(log_flags[15]), 64'd0);
    check("post reset word16 flags", 64'(log_flags[16]), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
